// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked multi-cycle execution unit.
// A request is captured in IDLE. Single-cycle ops resolve in EXEC. Shifts (and
// rotates, when enabled) step one bit per cycle in SHIFT. The result and its
// flags are registered on entry to DONE and are held until the response handshake.
// Optional feature: define ALU_SEQ_ROTATE_EN to make OP 9 (rotate left) and
// OP 10 (rotate right) legal. Without it they take the illegal-opcode path.
module alu_seq_unit #(
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_SHIFT = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Req_valid,
  output logic         Req_ready,
  input  logic [3:0]   OP,
  input  logic [W-1:0] InputA,
  input  logic [W-1:0] InputB,
  input  logic         SC_in,
  output logic         Rsp_valid,
  input  logic         Rsp_ready,
  output logic [W-1:0] Out,
  output logic         SC_out,
  output logic         Zero,
  output logic         Parity,
  output logic         Odd,
  output logic         Err
);

  localparam int unsigned CW = $clog2(MAX_SHIFT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XRB = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_LT  = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_ROR = 4'd10;

  // State and captured request
  logic [1:0]    r_state;
  logic [3:0]    r_op;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_ci;
  logic [W-1:0]  r_val;
  logic [CW-1:0] r_cnt;

  // Registered response
  logic [W-1:0]  r_out;
  logic          r_sc;
  logic          r_zero;
  logic          r_par;
  logic          r_odd;
  logic          r_err;

  // Combinational helpers
  logic          w_accept;
  logic          w_is_shift;
  logic [CW-1:0] w_cnt_load;
  logic [W:0]    w_sum;
  logic [W-1:0]  w_exec_res;
  logic          w_exec_co;
  logic          w_exec_ill;
  logic [W-1:0]  w_val_step;
  logic          w_fin_load;
  logic [W-1:0]  w_fin_out;
  logic          w_fin_co;
  logic          w_fin_err;

  assign Req_ready = (r_state == S_IDLE);
  assign Rsp_valid = (r_state == S_DONE);
  assign w_accept  = Req_valid && (r_state == S_IDLE);

  assign Out    = r_out;
  assign SC_out = r_sc;
  assign Zero   = r_zero;
  assign Parity = r_par;
  assign Odd    = r_odd;
  assign Err    = r_err;

  // Decide whether the incoming opcode takes the iterative shift path
  always_comb begin
    w_is_shift = (OP == OP_SHL) || (OP == OP_SHR);
`ifdef ALU_SEQ_ROTATE_EN
    if ((OP == OP_ROL) || (OP == OP_ROR)) begin
      w_is_shift = 1'b1;
    end
`endif
  end

  // Saturate the requested shift count at MAX_SHIFT
  always_comb begin
    if (32'(InputB) > MAX_SHIFT) begin
      w_cnt_load = CW'(MAX_SHIFT);
    end else begin
      w_cnt_load = CW'(InputB);
    end
  end

  // Single-cycle operations on the captured operands
  always_comb begin
    w_sum      = '0;
    w_exec_res = '0;
    w_exec_co  = 1'b0;
    w_exec_ill = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_sum      = {1'b0, r_a} + {1'b0, r_b} + {{W{1'b0}}, r_ci};
        w_exec_res = w_sum[W-1:0];
        w_exec_co  = w_sum[W];
      end
      OP_SUB: begin
        w_exec_res = r_a - r_b;
        w_exec_co  = (r_a < r_b);
      end
      OP_AND:  w_exec_res = r_a & r_b;
      OP_OR:   w_exec_res = r_a | r_b;
      OP_XRB:  w_exec_res = {{(W-1){1'b0}}, ^r_b};
      OP_EQ:   w_exec_res = {{(W-1){1'b0}}, (r_a == r_b)};
      OP_LT:   w_exec_res = {{(W-1){1'b0}}, (r_a < r_b)};
      // Shift-class opcodes never reach EXEC, so only illegal ones land here
      default: w_exec_ill = 1'b1;
    endcase
  end

  // One-bit step of the iterative shift/rotate
  always_comb begin
    w_val_step = r_val;
    case (r_op)
      OP_SHL:  w_val_step = r_val << 1;
      OP_SHR:  w_val_step = r_val >> 1;
`ifdef ALU_SEQ_ROTATE_EN
      OP_ROL:  w_val_step = {r_val[W-2:0], r_val[W-1]};
      OP_ROR:  w_val_step = {r_val[0], r_val[W-1:1]};
`endif
      default: w_val_step = r_val;
    endcase
  end

  // Select the value that lands in the response registers on entry to DONE
  always_comb begin
    w_fin_load = 1'b0;
    w_fin_out  = r_val;
    w_fin_co   = 1'b0;
    w_fin_err  = 1'b0;
    if (r_state == S_EXEC) begin
      w_fin_load = 1'b1;
      w_fin_out  = w_exec_ill ? '0 : w_exec_res;
      w_fin_co   = w_exec_ill ? 1'b0 : w_exec_co;
      w_fin_err  = w_exec_ill;
    end else if ((r_state == S_SHIFT) && (r_cnt == '0)) begin
      w_fin_load = 1'b1;
    end
  end

  // Control FSM plus request capture and shift iteration
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_ci    <= 1'b0;
      r_val   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= OP;
            r_a     <= InputA;
            r_b     <= InputB;
            r_ci    <= SC_in;
            r_val   <= InputA;
            r_cnt   <= w_cnt_load;
            r_state <= w_is_shift ? S_SHIFT : S_EXEC;
          end
        end
        S_EXEC: begin
          r_state <= S_DONE;
        end
        S_SHIFT: begin
          // A zero count exits immediately, so InputA passes through untouched
          if (r_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_val <= w_val_step;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (Rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Response registers: flags are derived from the very value being stored
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_out  <= '0;
      r_sc   <= 1'b0;
      r_zero <= 1'b1;
      r_par  <= 1'b0;
      r_odd  <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_fin_load) begin
      r_out  <= w_fin_out;
      r_sc   <= w_fin_co;
      r_zero <= (w_fin_out == '0);
      r_par  <= ^w_fin_out;
      r_odd  <= w_fin_out[0];
      r_err  <= w_fin_err;
    end
  end

  // The two channels are never open at the same time
  a_no_overlap: assert property (@(posedge Clk) disable iff (Reset)
    !(Req_ready && Rsp_valid));

  // Held flags always agree with the held result
  a_flags_consistent: assert property (@(posedge Clk) disable iff (Reset)
    (Zero == (Out == '0)) && (Parity == ^Out) && (Odd == Out[0]));

endmodule

// File: tb/tb_alu_seq_unit.sv
// Testbench for alu_seq_unit: directed scenarios plus randomized operations,
// each checked against a behavioural model of the opcode table.
// Latency is the number of rising edges from the accept edge through the edge
// on which Rsp_valid rises, both included.
module tb_alu_seq_unit;

  localparam int WD   = 8;
  localparam int MAXS = 8;

  logic          Clk;
  logic          Reset;
  logic          Req_valid;
  logic          Req_ready;
  logic [3:0]    OP;
  logic [WD-1:0] InputA;
  logic [WD-1:0] InputB;
  logic          SC_in;
  logic          Rsp_valid;
  logic          Rsp_ready;
  logic [WD-1:0] Out;
  logic          SC_out;
  logic          Zero;
  logic          Parity;
  logic          Odd;
  logic          Err;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq_unit #(.W(WD), .MAX_SHIFT(MAXS)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Req_valid (Req_valid),
    .Req_ready (Req_ready),
    .OP        (OP),
    .InputA    (InputA),
    .InputB    (InputB),
    .SC_in     (SC_in),
    .Rsp_valid (Rsp_valid),
    .Rsp_ready (Rsp_ready),
    .Out       (Out),
    .SC_out    (SC_out),
    .Zero      (Zero),
    .Parity    (Parity),
    .Odd       (Odd),
    .Err       (Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Opcode table expressed with plain integer arithmetic
  task automatic ref_model(input int op, input int a, input int b, input int ci,
                           output int o, output int co, output int err, output int lat);
    int n;
    n   = (b > MAXS) ? MAXS : b;
    o   = 0;
    co  = 0;
    err = 0;
    lat = 2;
    case (op)
      0: begin o = a + b + ci; co = (o > 255) ? 1 : 0; o = o % 256; end
      1: begin o = (a - b + 256) % 256; co = (a < b) ? 1 : 0; end
      2: o = a & b;
      3: o = a | b;
      4: o = $countones(b) % 2;
      5: begin o = (a << n) % 256; lat = 2 + n; end
      6: begin o = a >> n; lat = 2 + n; end
      7: o = (a == b) ? 1 : 0;
      8: o = (a < b) ? 1 : 0;
`ifdef ALU_SEQ_ROTATE_EN
      9:  begin o = ((a << n) | (a >> (WD - n))) % 256; lat = 2 + n; end
      10: begin o = ((a >> n) | (a << (WD - n))) % 256; lat = 2 + n; end
`endif
      default: err = 1;
    endcase
  endtask

  task automatic check_outputs(input string pfx, input int eo, input int eco, input int eerr);
    int ez;
    ez = (eo == 0) ? 1 : 0;
    check_eq({pfx, "_out"},    32'(Out),    eo);
    check_eq({pfx, "_sc"},     32'(SC_out), eco);
    check_eq({pfx, "_zero"},   32'(Zero),   ez);
    check_eq({pfx, "_parity"}, 32'(Parity), $countones(eo) % 2);
    check_eq({pfx, "_odd"},    32'(Odd),    eo % 2);
    check_eq({pfx, "_err"},    32'(Err),    eerr);
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_req_ready"}, 32'(Req_ready), 1);
    check_eq({pfx, "_rsp_valid"}, 32'(Rsp_valid), 0);
    check_outputs(pfx, 0, 0, 0);
  endtask

  // One full transaction; hold = cycles Rsp_ready stays low once DONE is reached
  task automatic do_op(input int op, input int a, input int b, input int ci, input int hold);
    int eo, eco, eerr, elat, edges;
    ref_model(op, a, b, ci, eo, eco, eerr, elat);
    @(negedge Clk);
    OP        = 4'(op);
    InputA    = 8'(a);
    InputB    = 8'(b);
    SC_in     = 1'(ci);
    Req_valid = 1'b1;
    Rsp_ready = (hold == 0);
    check_eq("req_ready_idle", 32'(Req_ready), 1);
    @(posedge Clk);
    #1;
    Req_valid = 1'b0;
    OP        = 4'($urandom);
    InputA    = 8'($urandom);
    InputB    = 8'($urandom);
    SC_in     = 1'($urandom);
    check_eq("busy_after_accept", 32'(Req_ready), 0);
    edges = 1;
    while (!Rsp_valid && edges < 64) begin
      @(posedge Clk);
      #1;
      edges++;
    end
    check_eq("latency", edges, elat);
    check_outputs("rsp", eo, eco, eerr);
    for (int i = 0; i < hold; i++) begin
      Req_valid = 1'($urandom);
      OP        = 4'($urandom);
      InputA    = 8'($urandom);
      @(posedge Clk);
      #1;
      check_eq("hold_rsp_valid", 32'(Rsp_valid), 1);
      check_eq("hold_req_ready", 32'(Req_ready), 0);
      check_outputs("hold", eo, eco, eerr);
    end
    if (hold > 0) begin
      // Keep a request pending across the handshake edge: it must not be taken there
      Req_valid = 1'b1;
      OP        = 4'd0;
      Rsp_ready = 1'b1;
    end
    @(posedge Clk);
    #1;
    Req_valid = 1'b0;
    check_eq("released_rsp_valid", 32'(Rsp_valid), 0);
    check_eq("released_req_ready", 32'(Req_ready), 1);
    Rsp_ready = 1'b1;
  endtask

  initial begin
    int seen;
    int op, a, b, ci, hold;
    Reset     = 1'b1;
    Req_valid = 1'b0;
    OP        = '0;
    InputA    = '0;
    InputB    = '0;
    SC_in     = 1'b0;
    Rsp_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check_reset_vals("reset");
    @(negedge Clk);
    Reset = 1'b0;

    do_op(0, 4, 1, 1, 0);
    do_op(0, 8'hFF, 8'h01, 0, 0);
    do_op(1, 8'h01, 8'h02, 0, 0);
    do_op(5, 8'h04, 3, 0, 0);
    do_op(6, 8'h80, 20, 0, 0);
    do_op(7, 4, 4, 0, 0);
    do_op(4, 0, 8'h07, 0, 0);
    do_op(8, 4, 1, 0, 0);
    do_op(5, 8'h5A, 0, 0, 0);
    do_op(2, 8'hF0, 8'h3C, 1, 5);
    do_op(12, 8'h12, 8'h34, 1, 0);
    do_op(0, 8'hA4, 0, 1, 0);

    // Reset in the middle of a shl by 7
    @(negedge Clk);
    OP        = 4'd5;
    InputA    = 8'h01;
    InputB    = 8'd7;
    Req_valid = 1'b1;
    @(posedge Clk);
    #1;
    Req_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_vals("midshift_reset");
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge Clk);
      #1;
      if (Rsp_valid) seen++;
    end
    check_eq("no_rsp_after_reset", seen, 0);
    check_eq("idle_after_reset", 32'(Req_ready), 1);

    do_op(9, 8'h81, 8'h01, 0, 0);
    do_op(10, 8'h81, 8'h03, 0, 0);

    for (int k = 0; k < 200; k++) begin
      op   = int'($urandom_range(0, 15));
      a    = int'($urandom_range(0, 255));
      b    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 255));
      ci   = int'($urandom_range(0, 1));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_op(op, a, b, ci, hold);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
